// File: rtl/game_pkg.sv
// Shared encodings for the morse guessing game controller.
// States, player2 per-symbol result codes and morse symbols.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_ENTRY  = 3'd1,
        P2_GUESS  = 3'd2,
        ROUND_WIN = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] NEUTRAL   = 2'b00;
    localparam logic [1:0] CORRECT   = 2'b01;
    localparam logic [1:0] INCORRECT = 2'b10;

    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b10;

endpackage

// File: rtl/round_timer.sv
// Per-attempt countdown; expired flags the tick that takes it to zero,
// so the controller reloads it in that same cycle.
module round_timer
    import game_pkg::*;
#(
    parameter int TIME_LIMIT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       tick,
    output logic [5:0] value,
    output logic       expired
);

    assign expired = tick && (value <= 6'd1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            value <= '0;
        end else if (load) begin
            value <= 6'(TIME_LIMIT);
        end else if (tick && value != '0) begin
            value <= value - 6'd1;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM: player1 enters a code, player2 guesses it
// within a time and lives budget, over a fixed number of rounds.
module game_ctrl
    import game_pkg::*;
#(
    parameter int MAX_LIVES  = 3,
    parameter int TIME_LIMIT = 30,
    parameter int MAX_ROUNDS = 9
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick,
    input  logic       p1_done,
    input  logic [9:0] p1_value,
    input  logic [1:0] p2_correct,
    input  logic       p2_complete,
    output logic       p1_en,
    output logic       p2_en,
    output logic       p2_clear,
    output logic [9:0] code,
    output logic [2:0] lives,
    output logic [3:0] round,
    output logic [5:0] timer,
    output logic [2:0] state,
    output logic       win,
    output logic       lose
);

    state_t     cur, nxt;
    logic [9:0] code_n;
    logic [2:0] lives_n;
    logic [3:0] round_n;
    logic       win_n, lose_n, clear_n;
    logic       load, tick_en, expired, miss;

    // A completed guess freezes the countdown so it cannot also expire.
    assign tick_en = (cur == P2_GUESS) && tick && !p2_complete;
    assign miss    = (p2_correct == INCORRECT);
    assign state   = cur;

    round_timer #(
        .TIME_LIMIT(TIME_LIMIT)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .load   (load),
        .tick   (tick_en),
        .value  (timer),
        .expired(expired)
    );

    always_comb begin
        nxt     = cur;
        code_n  = code;
        lives_n = lives;
        round_n = round;
        win_n   = win;
        lose_n  = lose;
        clear_n = 1'b0;
        load    = 1'b0;
        unique case (cur)
            IDLE: begin
                if (start) begin
                    lives_n = 3'(MAX_LIVES);
                    round_n = 4'd1;
                    nxt     = P1_ENTRY;
                end
            end
            P1_ENTRY: begin
                if (p1_done && p1_value != '0) begin
                    code_n  = p1_value;
                    load    = 1'b1;
                    clear_n = 1'b1;
                    nxt     = P2_GUESS;
                end
            end
            P2_GUESS: begin
                if (p2_complete) begin
                    nxt = ROUND_WIN;
                end else if (miss || expired) begin
                    lives_n = (lives != '0) ? lives - 3'd1 : 3'd0;
                    load    = 1'b1;
                    clear_n = 1'b1;
                    if (lives <= 3'd1) begin
                        nxt    = GAME_OVER;
                        lose_n = 1'b1;
                    end
                end
            end
            ROUND_WIN: begin
                if (round >= 4'(MAX_ROUNDS)) begin
                    nxt   = GAME_OVER;
                    win_n = 1'b1;
                end else begin
                    round_n = round + 4'd1;
                    clear_n = 1'b1;
                    nxt     = P1_ENTRY;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    lives_n = 3'(MAX_LIVES);
                    round_n = 4'd1;
                    win_n   = 1'b0;
                    lose_n  = 1'b0;
                    nxt     = P1_ENTRY;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur      <= IDLE;
            code     <= '0;
            lives    <= '0;
            round    <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
            p2_clear <= 1'b0;
            p1_en    <= 1'b0;
            p2_en    <= 1'b0;
        end else begin
            cur      <= nxt;
            code     <= code_n;
            lives    <= lives_n;
            round    <= round_n;
            win      <= win_n;
            lose     <= lose_n;
            p2_clear <= clear_n;
            p1_en    <= (nxt == P1_ENTRY);
            p2_en    <= (nxt == P2_GUESS);
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters.
module tb_game_ctrl;

    logic       clock = 1'b0;
    logic       resetn, start, tick, p1_done, p2_complete;
    logic [9:0] p1_value;
    logic [1:0] p2_correct;
    logic       p1_en, p2_en, p2_clear, win, lose;
    logic [9:0] code;
    logic [2:0] lives, state;
    logic [3:0] round;
    logic [5:0] timer;

    int n_assert = 0;
    int n_fail   = 0;

    game_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .tick       (tick),
        .p1_done    (p1_done),
        .p1_value   (p1_value),
        .p2_correct (p2_correct),
        .p2_complete(p2_complete),
        .p1_en      (p1_en),
        .p2_en      (p2_en),
        .p2_clear   (p2_clear),
        .code       (code),
        .lives      (lives),
        .round      (round),
        .timer      (timer),
        .state      (state),
        .win        (win),
        .lose       (lose)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " state"}, 16'(state), 16'd0);
        chk({tag, " code"}, 16'(code), 16'd0);
        chk({tag, " lives"}, 16'(lives), 16'd0);
        chk({tag, " round"}, 16'(round), 16'd0);
        chk({tag, " timer"}, 16'(timer), 16'd0);
        chk({tag, " bits"}, 16'({p1_en, p2_en, p2_clear, win, lose}), 16'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; tick = 1'b0; p1_done = 1'b0;
        p1_value = '0; p2_correct = 2'b00; p2_complete = 1'b0;
        step();
        step();
        chk_zero("reset");

        resetn = 1'b1;
        step();
        chk("idle hold", 16'(state), 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start state", 16'(state), 16'd1);
        chk("start lives", 16'(lives), 16'd3);
        chk("start round", 16'(round), 16'd1);
        chk("start p1_en", 16'(p1_en), 16'd1);

        p1_done = 1'b1;
        p1_value = '0;
        step();
        chk("zero code ignored", 16'(state), 16'd1);
        p1_value = 10'b0101110000;
        step();
        p1_done = 1'b0;
        chk("p1 commit state", 16'(state), 16'd2);
        chk("p1 commit code", 16'(code), 16'h170);
        chk("p1 commit timer", 16'(timer), 16'd30);
        chk("p1 commit clear", 16'(p2_clear), 16'd1);
        chk("p1 commit en", 16'({p1_en, p2_en}), 16'b01);
        step();
        chk("clear one pulse", 16'(p2_clear), 16'd0);

        tick = 1'b1;
        repeat (29) step();
        chk("29 ticks timer", 16'(timer), 16'd1);
        chk("29 ticks lives", 16'(lives), 16'd3);
        step();
        tick = 1'b0;
        chk("timeout lives", 16'(lives), 16'd2);
        chk("timeout reload", 16'(timer), 16'd30);
        chk("timeout clear", 16'(p2_clear), 16'd1);
        step();
        chk("timeout clear end", 16'(p2_clear), 16'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start ignored", 16'(state), 16'd2);

        p2_correct = 2'b10;
        step();
        p2_correct = 2'b00;
        chk("miss lives", 16'(lives), 16'd1);
        chk("miss state", 16'(state), 16'd2);
        chk("miss clear", 16'(p2_clear), 16'd1);

        tick = 1'b1;
        repeat (29) step();
        chk("pre-win timer", 16'(timer), 16'd1);
        p2_complete = 1'b1;
        p2_correct = 2'b10;
        step();
        tick = 1'b0;
        p2_complete = 1'b0;
        p2_correct = 2'b00;
        chk("win priority state", 16'(state), 16'd3);
        chk("win priority lives", 16'(lives), 16'd1);
        step();
        chk("next round state", 16'(state), 16'd1);
        chk("next round round", 16'(round), 16'd2);
        chk("next round clear", 16'(p2_clear), 16'd1);

        for (int r = 2; r <= 9; r++) begin
            p1_done = 1'b1;
            p1_value = 10'(r);
            step();
            p1_done = 1'b0;
            chk("round guess", 16'(state), 16'd2);
            p2_complete = 1'b1;
            step();
            p2_complete = 1'b0;
            chk("round win", 16'(state), 16'd3);
            step();
            if (r < 9) begin
                chk("round advance", 16'(round), 16'(r + 1));
            end
        end
        chk("game won state", 16'(state), 16'd4);
        chk("game won flags", 16'({win, lose}), 16'b10);
        chk("game won round", 16'(round), 16'd9);
        step();
        chk("game over hold", 16'({state, win}), 16'({3'd4, 1'b1}));

        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart state", 16'(state), 16'd1);
        chk("restart lives", 16'(lives), 16'd3);
        chk("restart round", 16'(round), 16'd1);
        chk("restart flags", 16'({win, lose}), 16'd0);

        p1_done = 1'b1;
        p1_value = 10'b1010101010;
        step();
        p1_done = 1'b0;
        chk("game b code", 16'(code), 16'h2AA);
        p2_correct = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lose lives", 16'(lives), 16'(2 - i));
        end
        chk("lose state", 16'(state), 16'd4);
        chk("lose flags", 16'({win, lose}), 16'b01);
        step();
        p2_correct = 2'b00;
        chk("no underflow", 16'(lives), 16'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        p1_done = 1'b1;
        step();
        p1_done = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("mid game timer", 16'(timer), 16'd29);
        resetn = 1'b0;
        step();
        chk_zero("mid reset");
        resetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
